// File: rtl/gfx_arbiter.sv
// gfx_arbiter: two-requester pixel stream arbiter feeding one framebuffer writer.
// A requester owns the output for a whole burst (up to its last beat). Ties
// in IDLE go to the port that did not finish the previous burst, and an
// ending burst hands over directly to a waiting peer without an idle cycle.
// Optional feature macro: GFX_ARB_BURST_LIMIT_EN
//   When defined, a grant also ends on the accepted beat that brings beat_cnt
//   to MAX_BURST, even if that beat is not marked last.
module gfx_arbiter #(
    parameter int FB_X_BITS  = 10,
    parameter int FB_Y_BITS  = 9,
    parameter int PIXEL_BITS = 12,
    parameter int META_BITS  = 4,
    parameter int MAX_BURST  = 64
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [FB_X_BITS-1:0]          s0_x,
    input  logic [FB_X_BITS-1:0]          s1_x,
    input  logic [FB_Y_BITS-1:0]          s0_y,
    input  logic [FB_Y_BITS-1:0]          s1_y,
    input  logic [PIXEL_BITS-1:0]         s0_color,
    input  logic [PIXEL_BITS-1:0]         s1_color,
    input  logic [META_BITS-1:0]          s0_meta,
    input  logic [META_BITS-1:0]          s1_meta,
    input  logic                          s0_last,
    input  logic                          s1_last,
    input  logic                          s0_valid,
    input  logic                          s1_valid,
    output logic                          s0_ready,
    output logic                          s1_ready,
    output logic [FB_X_BITS-1:0]          m_x,
    output logic [FB_Y_BITS-1:0]          m_y,
    output logic [PIXEL_BITS-1:0]         m_color,
    output logic [META_BITS-1:0]          m_meta,
    output logic                          m_last,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic [1:0]                    grant,
    output logic [$clog2(MAX_BURST+1)-1:0] beat_cnt
);

    localparam int CNT_W = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } state_t;

    state_t           state_r;
    logic             last_grant_r;   // index of the port that finished the last burst
    logic             acc0_s;
    logic             acc1_s;
    logic             limit_hit_s;
    logic             end0_s;
    logic             end1_s;
    logic [CNT_W-1:0] cnt_inc_s;

`ifdef GFX_ARB_BURST_LIMIT_EN
    localparam logic [CNT_W-1:0] LIMIT_M1 = CNT_W'(MAX_BURST - 1);
`endif

    // Beat acceptance, burst-end and saturating count terms for the FSM.
    always_comb begin
        acc0_s = s0_valid & m_ready;
        acc1_s = s1_valid & m_ready;
`ifdef GFX_ARB_BURST_LIMIT_EN
        limit_hit_s = (beat_cnt == LIMIT_M1);
`else
        limit_hit_s = 1'b0;
`endif
        end0_s = s0_last | limit_hit_s;
        end1_s = s1_last | limit_hit_s;
        if (beat_cnt == CNT_MAX) begin
            cnt_inc_s = beat_cnt;
        end else begin
            cnt_inc_s = beat_cnt + CNT_ONE;
        end
    end

    // Ownership FSM with registered grant, beat counter and tie-break pointer.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= IDLE;
            grant        <= 2'b00;
            last_grant_r <= 1'b1;
            beat_cnt     <= CNT_ZERO;
        end else begin
            case (state_r)
                IDLE: begin
                    if (s0_valid && (!s1_valid || last_grant_r)) begin
                        state_r <= GRANT0;
                        grant   <= 2'b01;
                    end else if (s1_valid) begin
                        state_r <= GRANT1;
                        grant   <= 2'b10;
                    end else begin
                        state_r <= IDLE;
                        grant   <= 2'b00;
                    end
                end
                GRANT0: begin
                    if (acc0_s && end0_s) begin
                        last_grant_r <= 1'b0;
                        beat_cnt     <= CNT_ZERO;
                        if (s1_valid) begin
                            state_r <= GRANT1;
                            grant   <= 2'b10;
                        end else begin
                            state_r <= IDLE;
                            grant   <= 2'b00;
                        end
                    end else if (acc0_s) begin
                        beat_cnt <= cnt_inc_s;
                    end else begin
                        beat_cnt <= beat_cnt;
                    end
                end
                GRANT1: begin
                    if (acc1_s && end1_s) begin
                        last_grant_r <= 1'b1;
                        beat_cnt     <= CNT_ZERO;
                        if (s0_valid) begin
                            state_r <= GRANT0;
                            grant   <= 2'b01;
                        end else begin
                            state_r <= IDLE;
                            grant   <= 2'b00;
                        end
                    end else if (acc1_s) begin
                        beat_cnt <= cnt_inc_s;
                    end else begin
                        beat_cnt <= beat_cnt;
                    end
                end
                default: begin
                    state_r  <= IDLE;
                    grant    <= 2'b00;
                    beat_cnt <= CNT_ZERO;
                end
            endcase
        end
    end

    // Output steering: owner's beat passes straight through, zeros when idle.
    always_comb begin
        m_x      = {FB_X_BITS{1'b0}};
        m_y      = {FB_Y_BITS{1'b0}};
        m_color  = {PIXEL_BITS{1'b0}};
        m_meta   = {META_BITS{1'b0}};
        m_last   = 1'b0;
        m_valid  = 1'b0;
        s0_ready = 1'b0;
        s1_ready = 1'b0;
        case (state_r)
            GRANT0: begin
                m_x      = s0_x;
                m_y      = s0_y;
                m_color  = s0_color;
                m_meta   = s0_meta;
                m_last   = s0_last;
                m_valid  = s0_valid;
                s0_ready = m_ready;
            end
            GRANT1: begin
                m_x      = s1_x;
                m_y      = s1_y;
                m_color  = s1_color;
                m_meta   = s1_meta;
                m_last   = s1_last;
                m_valid  = s1_valid;
                s1_ready = m_ready;
            end
            default: begin
                m_valid  = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_gfx_arbiter.sv
// Bench for gfx_arbiter: directed scenarios plus randomized traffic, all
// checked every cycle against a burst-level ownership model.
module tb_gfx_arbiter;

    localparam int XB = 10;
    localparam int YB = 9;
    localparam int PB = 12;
    localparam int MB = 4;
`ifdef GFX_ARB_BURST_LIMIT_EN
    localparam int MAXB = 4;
    localparam bit LIM  = 1'b1;
`else
    localparam int MAXB = 64;
    localparam bit LIM  = 1'b0;
`endif
    localparam int CW   = $clog2(MAXB + 1);
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          reset;
    logic [XB-1:0] s0_x, s1_x, m_x;
    logic [YB-1:0] s0_y, s1_y, m_y;
    logic [PB-1:0] s0_color, s1_color, m_color;
    logic [MB-1:0] s0_meta, s1_meta, m_meta;
    logic          s0_last, s1_last, m_last;
    logic          s0_valid, s1_valid, m_valid;
    logic          s0_ready, s1_ready, m_ready;
    logic [1:0]    grant;
    logic [CW-1:0] beat_cnt;

    gfx_arbiter #(
        .FB_X_BITS(XB), .FB_Y_BITS(YB), .PIXEL_BITS(PB),
        .META_BITS(MB), .MAX_BURST(MAXB)
    ) dut (
        .clk(clk), .reset(reset),
        .s0_x(s0_x), .s1_x(s1_x), .s0_y(s0_y), .s1_y(s1_y),
        .s0_color(s0_color), .s1_color(s1_color),
        .s0_meta(s0_meta), .s1_meta(s1_meta),
        .s0_last(s0_last), .s1_last(s1_last),
        .s0_valid(s0_valid), .s1_valid(s1_valid),
        .s0_ready(s0_ready), .s1_ready(s1_ready),
        .m_x(m_x), .m_y(m_y), .m_color(m_color), .m_meta(m_meta),
        .m_last(m_last), .m_valid(m_valid), .m_ready(m_ready),
        .grant(grant), .beat_cnt(beat_cnt)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: who owns the output (0 none, 1 port0, 2 port1),
    // which port finished last, beats taken in this grant.
    int owner = 0;
    int lastg = 1;
    int cnt   = 0;
    // Source model: per-port beat sequence number and beats left in burst.
    int seq[2];
    int rem[2];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic drive_src();
        s0_x     = seq[0][XB-1:0];
        s1_x     = seq[1][XB-1:0] ^ 10'h200;
        s0_y     = YB'(seq[0] * 3);
        s1_y     = YB'(seq[1] * 5 + 1);
        s0_color = PB'(seq[0] * 37 + 11);
        s1_color = PB'(seq[1] * 91 + 7);
        s0_meta  = MB'(seq[0]);
        s1_meta  = MB'(seq[1] + 8);
        s0_last  = (rem[0] == 1);
        s1_last  = (rem[1] == 1);
    endtask

    // Apply the ownership rules for one clock edge using the current inputs.
    task automatic model_step();
        int  p;
        bit  v, lf, ov;
        if (reset) begin
            owner = 0; lastg = 1; cnt = 0;
        end else if (owner == 0) begin
            if (s0_valid && s1_valid) owner = (lastg == 1) ? 1 : 2;
            else if (s0_valid)        owner = 1;
            else if (s1_valid)        owner = 2;
        end else begin
            p  = owner - 1;
            v  = (p == 1) ? s1_valid : s0_valid;
            lf = (p == 1) ? s1_last  : s0_last;
            ov = (p == 1) ? s0_valid : s1_valid;
            if (v && m_ready) begin
                seq[p]++;
                rem[p]--;
                if (rem[p] == 0) rem[p] = $urandom_range(1, 6);
                cnt++;
                if (lf || (LIM && cnt == MAXB)) begin
                    lastg = p;
                    cnt   = 0;
                    owner = ov ? (2 - p) : 0;
                end else if (cnt > CMAX) begin
                    cnt = CMAX;
                end
            end
        end
    endtask

    // One clock: check outputs at the falling edge, advance model at rising.
    task automatic cycle();
        logic [31:0] ex, ey, ec, em, el, ev;
        @(negedge clk);
        ex = 0; ey = 0; ec = 0; em = 0; el = 0; ev = 0;
        if (owner == 1) begin
            ex = s0_x; ey = s0_y; ec = s0_color; em = s0_meta; el = s0_last; ev = s0_valid;
        end else if (owner == 2) begin
            ex = s1_x; ey = s1_y; ec = s1_color; em = s1_meta; el = s1_last; ev = s1_valid;
        end
        check_eq("grant",    grant,    (owner == 1) ? 1 : (owner == 2) ? 2 : 0);
        check_eq("s0_ready", s0_ready, (owner == 1) ? m_ready : 0);
        check_eq("s1_ready", s1_ready, (owner == 2) ? m_ready : 0);
        check_eq("m_valid",  m_valid,  ev);
        check_eq("beat_cnt", beat_cnt, cnt);
        check_eq("m_x",      m_x,      ex);
        check_eq("m_y",      m_y,      ey);
        check_eq("m_color",  m_color,  ec);
        check_eq("m_meta",   m_meta,   em);
        check_eq("m_last",   m_last,   el);
        @(posedge clk);
        model_step();
        #1;
        drive_src();
    endtask

    task automatic do_reset();
        reset = 1'b1; s0_valid = 1'b0; s1_valid = 1'b0;
        cycle();
        reset = 1'b0;
    endtask

    initial begin
        int s;
        seq[0] = 0; seq[1] = 0; rem[0] = 3; rem[1] = 3;
        reset = 1'b1; s0_valid = 1'b0; s1_valid = 1'b0; m_ready = 1'b1;
        drive_src();
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_grant", grant, 0);
        check_eq("rst_cnt",   beat_cnt, 0);
        check_eq("rst_mvalid", m_valid, 0);
        check_eq("rst_mx",    m_x, 0);
        cycle();
        reset = 1'b0;

        // Both request after reset: port 0 wins, first beat a cycle later.
        s0_valid = 1'b1; s1_valid = 1'b1; m_ready = 1'b1;
        cycle();
        check_eq("r17_grant", grant, 1);
        check_eq("r17_mx", m_x, s0_x);

        // Four-beat s0 burst hands over to s1 with no idle cycle.
        do_reset();
        rem[0] = 4; drive_src();
        s0_valid = 1'b1; s1_valid = 1'b1; m_ready = 1'b1;
        cycle();
        for (int i = 0; i < 4; i++) begin
            check_eq("r18_g0", grant, 1);
            cycle();
        end
        check_eq("r18_g1", grant, 2);

        // Stalled s1 burst: count advances only on ready cycles.
        do_reset();
        rem[1] = 5; drive_src();
        s0_valid = 1'b0; s1_valid = 1'b1; m_ready = 1'b1;
        cycle();
        for (int i = 0; i < 4; i++) begin
            m_ready = (i % 2 == 0);
            cycle();
        end
        check_eq("r19_cnt", beat_cnt, 2);
        check_eq("r19_grant", grant, 2);
        m_ready = 1'b1;

        // s0 pauses mid-burst: grant held, s1 kept waiting.
        do_reset();
        rem[0] = 6; drive_src();
        s0_valid = 1'b1; s1_valid = 1'b1;
        cycle();
        cycle();
        s0_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            check_eq("r20_grant", grant, 1);
            check_eq("r20_s1rdy", s1_ready, 0);
        end
        s0_valid = 1'b1;
        cycle();

        // Reset during beat 2 of an s1 burst abandons it.
        do_reset();
        rem[1] = 5; drive_src();
        s0_valid = 1'b0; s1_valid = 1'b1;
        cycle();
        cycle();
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        check_eq("r21_grant", grant, 0);
        check_eq("r21_cnt", beat_cnt, 0);
        s0_valid = 1'b1; s1_valid = 1'b1;
        cycle();
        check_eq("r21_regrant", grant, 1);

`ifdef GFX_ARB_BURST_LIMIT_EN
        // Long s0 burst is cut at MAX_BURST, s1 runs, s0 resumes at beat 5.
        do_reset();
        rem[0] = 10; rem[1] = 2; drive_src();
        s = seq[0];
        s0_valid = 1'b1; s1_valid = 1'b1; m_ready = 1'b1;
        cycle();
        for (int i = 0; i < 4; i++) begin
            check_eq("r22_g0", grant, 1);
            cycle();
        end
        check_eq("r22_g1", grant, 2);
        cycle();
        cycle();
        check_eq("r22_resume", grant, 1);
        check_eq("r22_mx", m_x, XB'(s + 4));
`endif

        // Randomized traffic with occasional resets.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            s0_valid = ($urandom_range(0, 3) != 0);
            s1_valid = ($urandom_range(0, 3) != 0);
            m_ready  = ($urandom_range(0, 3) != 0);
            reset    = ($urandom_range(0, 199) == 0);
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
